// File: rtl/zero_cross_det.sv
// zero_cross_det: hysteresis zero-crossing detector for the pilot-tone path.
//
// Converts a signed tone sample stream into a debounced square wave for the
// DPLL sigin input. It also measures the rising-to-rising period in CLK cycles
// and flags whether that period lies inside the PLL capture range.
//
// Ports:
//   CLK          in   system clock (100 MHz)
//   RST          in   synchronous reset, active-high
//   sample_in    in   signed tone sample, DATA_W bits, two's complement
//   sample_valid in   qualifies sample_in for one cycle
//   sigout       out  conditioned square wave (registered)
//   edge_pulse   out  one-cycle pulse on each LOW->HIGH transition
//                     (`edge` is a reserved word in SystemVerilog)
//   period       out  last measured rising-to-rising interval, CLK cycles
//   period_valid out  one-cycle pulse when period updates
//   in_range     out  last period was within [PERIOD_MIN, PERIOD_MAX]
//
// Build option:
//   ZCD_SQUELCH_EN  when defined, sigout is forced low while in_range is 0 and
//                   only rises on a transition that also sets in_range.

module zero_cross_det #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned HYST       = 256,
  parameter int unsigned HOLD       = 4,
  parameter int unsigned PERIOD_MIN = 1695,
  parameter int unsigned PERIOD_MAX = 2857
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sigout,
  output logic              edge_pulse,
  output logic [15:0]       period,
  output logic              period_valid,
  output logic              in_range
);

  localparam logic signed [DATA_W-1:0] HystPos  = DATA_W'(HYST);
  localparam logic signed [DATA_W-1:0] HystNeg  = -HystPos;
  localparam logic [3:0]               HoldCnt  = 4'(HOLD);
  localparam logic [15:0]              PerMin   = 16'(PERIOD_MIN);
  localparam logic [15:0]              PerMax   = 16'(PERIOD_MAX);
  localparam logic [15:0]              PerLoss  = 16'(PERIOD_MAX + 1);

  typedef enum logic [0:0] {StLow, StHigh} state_e;

  state_e      state_q, state_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        seen_q, seen_d;
  logic [15:0] period_q, period_d;
  logic        period_valid_q, period_valid_d;
  logic        in_range_q, in_range_d;
  logic        sigout_q, sigout_d;
  logic        edge_q;

  logic signed [DATA_W-1:0] sample_s;
  logic                     qualify;
  logic                     rise;
  logic                     fall;

  assign sample_s = $signed(sample_in);

  // Hysteresis qualification and state transitions.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    rise    = 1'b0;
    fall    = 1'b0;
    qualify = (state_q == StLow) ? (sample_s > HystPos) : (sample_s < HystNeg);
    if (sample_valid) begin
      if (qualify) begin
        if (dwell_q + 4'd1 == HoldCnt) begin
          dwell_d = 4'd0;
          if (state_q == StLow) begin
            state_d = StHigh;
            rise    = 1'b1;
          end else begin
            state_d = StLow;
            fall    = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end else begin
        dwell_d = 4'd0;
      end
    end
  end

  // Period measurement. pcnt holds P at the rising edge that closes a period
  // of P cycles because it is loaded with 1 on the opening edge.
  always_comb begin
    pcnt_d         = (pcnt_q == 16'hFFFF) ? pcnt_q : pcnt_q + 16'd1;
    seen_d         = seen_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    in_range_d     = in_range_q;
    if (rise) begin
      pcnt_d = 16'd1;
      seen_d = 1'b1;
      if (seen_q) begin
        period_d       = pcnt_q;
        period_valid_d = 1'b1;
        in_range_d     = (pcnt_q >= PerMin) && (pcnt_q <= PerMax);
      end
    end else if (pcnt_q == PerLoss) begin
      // No rising edge within the longest accepted period: loss of signal.
      in_range_d = 1'b0;
    end
  end

`ifdef ZCD_SQUELCH_EN
  always_comb begin
    sigout_d = sigout_q;
    if (!in_range_d) begin
      sigout_d = 1'b0;
    end else if (rise) begin
      sigout_d = 1'b1;
    end else if (fall) begin
      sigout_d = 1'b0;
    end
  end
`else
  always_comb begin
    sigout_d = (state_d == StHigh);
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StLow;
      dwell_q        <= 4'd0;
      pcnt_q         <= 16'd0;
      seen_q         <= 1'b0;
      period_q       <= 16'd0;
      period_valid_q <= 1'b0;
      in_range_q     <= 1'b0;
      sigout_q       <= 1'b0;
      edge_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      dwell_q        <= dwell_d;
      pcnt_q         <= pcnt_d;
      seen_q         <= seen_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      in_range_q     <= in_range_d;
      sigout_q       <= sigout_d;
      edge_q         <= rise;
    end
  end

  assign sigout       = sigout_q;
  assign edge_pulse   = edge_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign in_range     = in_range_q;

endmodule

// File: tb/tb_zero_cross_det.sv
// Self-checking bench for zero_cross_det with default parameters
// (HYST=256, HOLD=4, PERIOD_MIN=1695, PERIOD_MAX=2857).

module tb_zero_cross_det;

`ifdef ZCD_SQUELCH_EN
  localparam bit Squelch = 1'b1;
`else
  localparam bit Squelch = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sigout;
  logic        edge_pulse;
  logic [15:0] period;
  logic        period_valid;
  logic        in_range;

  int checks;
  int errors;

  zero_cross_det dut (
    .CLK          (CLK),
    .RST          (RST),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sigout       (sigout),
    .edge_pulse   (edge_pulse),
    .period       (period),
    .period_valid (period_valid),
    .in_range     (in_range)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid;
    logic [15:0] sample;
    logic        exp_sig;
    logic        exp_edge;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] s16(input int v);
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    RST          = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    tick();
    RST = 1'b0;
  endtask

  task automatic add_vec(input logic v, input int s, input logic sg, input logic eg);
    vec_t t;
    t.valid    = v;
    t.sample   = s16(s);
    t.exp_sig  = sg;
    t.exp_edge = eg;
    vecs.push_back(t);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    RST          = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;

    // Hysteresis / dwell table, starting from reset (LOW, dwell 0).
    add_vec(1, 256,    0, 0);  // exactly +HYST does not qualify
    add_vec(1, -20000, 0, 0);
    add_vec(1, 257,    0, 0);
    add_vec(1, 257,    0, 0);
    add_vec(1, 257,    0, 0);  // 3-sample burst
    add_vec(1, 0,      0, 0);  // clears dwell
    add_vec(1, 8000,   0, 0);
    add_vec(1, 8000,   0, 0);
    add_vec(1, 256,    0, 0);  // clears dwell
    add_vec(1, 8000,   0, 0);
    add_vec(1, 8000,   0, 0);
    add_vec(1, 8000,   0, 0);
    add_vec(0, -20000, 0, 0);  // not valid: dwell held
    add_vec(1, 257,    1, 1);  // 4th qualifying sample: rise
    add_vec(0, 0,      1, 0);
    add_vec(1, -256,   1, 0);  // exactly -HYST does not qualify
    add_vec(1, -257,   1, 0);
    add_vec(1, -8000,  1, 0);
    add_vec(1, -8000,  1, 0);
    add_vec(1, -255,   1, 0);  // clears dwell
    add_vec(1, -8000,  1, 0);
    add_vec(1, -8000,  1, 0);
    add_vec(1, -8000,  1, 0);
    add_vec(1, -8000,  0, 0);  // fall, no edge pulse
    add_vec(1, 8000,   0, 0);

    // Reset with active, large inputs.
    for (int i = 0; i < 3; i++) begin
      RST          = 1'b1;
      sample_valid = (i % 2 == 0);
      sample_in    = (i % 2 == 0) ? s16(20000) : s16(-20000);
      tick();
      chk("rst_sigout", sigout, 0);
      chk("rst_edge", edge_pulse, 0);
      chk("rst_period", period, 0);
      chk("rst_pv", period_valid, 0);
      chk("rst_in_range", in_range, 0);
    end
    RST          = 1'b0;
    sample_valid = 1'b0;
    tick();
    chk("post_rst_edge", edge_pulse, 0);
    chk("post_rst_sigout", sigout, 0);

    // Table-driven hysteresis vectors.
    do_reset();
    foreach (vecs[i]) begin
      sample_valid = vecs[i].valid;
      sample_in    = vecs[i].sample;
      tick();
      chk($sformatf("vec%0d_sigout", i), sigout, vecs[i].exp_sig & ~Squelch);
      chk($sformatf("vec%0d_edge", i), edge_pulse, vecs[i].exp_edge);
      chk($sformatf("vec%0d_pv", i), period_valid, 0);
      chk($sformatf("vec%0d_in_range", i), in_range, 0);
    end

    // Reset in the middle of a qualification.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_in    = s16(8000);
      tick();
      chk("midq_pre_edge", edge_pulse, 0);
    end
    RST          = 1'b1;
    sample_valid = 1'b0;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_in    = s16(8000);
      tick();
      chk("midq_edge", edge_pulse, (i == 3));
      chk("midq_sigout", sigout, (i == 3) & ~Squelch);
    end
    sample_valid = 1'b0;

    // Clean tone at period 2000, then held high for loss of signal.
    do_reset();
    for (int c = 0; c < 11300; c++) begin
      bit e_edge, e_state, e_ir, e_sig, e_pv;
      sample_valid = (c % 100 == 0);
      sample_in    = (c >= 8000 || (c % 2000) < 1000) ? s16(8000) : s16(-8000);
      tick();
      e_edge  = (c % 2000 == 300) && (c <= 8300);
      e_state = (c < 8300) ? (c >= 300 && ((c - 300) % 2000) < 1000) : 1'b1;
      e_ir    = (c >= 2300) && (c < 11158);
      e_sig   = Squelch ? (e_state && e_ir) : e_state;
      e_pv    = e_edge && (c >= 2300);
      chk("tone_sigout", sigout, e_sig);
      chk("tone_edge", edge_pulse, e_edge);
      chk("tone_pv", period_valid, e_pv);
      chk("tone_in_range", in_range, e_ir);
      chk("tone_period", period, (c >= 2300) ? 2000 : 0);
    end

    // Out-of-range tone at period 1000, then tone stops.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit e_edge;
      sample_valid = (c % 50 == 0);
      sample_in    = ((c % 1000) < 500) ? s16(8000) : s16(-8000);
      tick();
      e_edge = (c % 1000 == 150);
      chk("oor_edge", edge_pulse, e_edge);
      chk("oor_pv", period_valid, e_edge && (c >= 1150));
      chk("oor_in_range", in_range, 0);
      chk("oor_period", period, (c >= 1150) ? 1000 : 0);
    end
    sample_valid = 1'b0;
    for (int c = 4000; c < 68700; c++) begin
      tick();
      chk("quiet_in_range", in_range, 0);
      chk("quiet_pv", period_valid, 0);
      if (c == 68683) chk("pcnt_pre_sat", dut.pcnt_q, 16'hFFFE);
    end
    chk("pcnt_sat", dut.pcnt_q, 16'hFFFF);
    for (int i = 0; i < 10; i++) tick();
    chk("pcnt_no_wrap", dut.pcnt_q, 16'hFFFF);
    chk("quiet_period", period, 1000);
    chk("quiet_sigout", sigout, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
